// File: rtl/mole_hit_judge_pkg.sv
// Shared definitions for the whack-a-mole hit judge: widths and game states.
package mole_hit_judge_pkg;

  localparam int unsigned N_MOLES = 8;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned MISS_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    ROUND,
    SETTLE,
    OVER
  } game_state_t;

endpackage

// File: rtl/mole_hit_judge_popcount8.sv
// Combinational population count of an 8-bit vector.
module popcount8 (
  input  logic [7:0] bits,
  output logic [3:0] count
);

  // Sum the set bits.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      count = count + {3'b000, bits[i]};
    end
  end

endmodule

// File: rtl/mole_hit_judge.sv
// Mole hit judge: latches mole patterns, judges switch toggles as whacks,
// reports per-cycle hits and tracks misses, lives and game over.
module mole_hit_judge
  import mole_hit_judge_pkg::*;
#(
  parameter int unsigned ROUND_TICKS = 4,
  parameter int unsigned LIVES_INIT  = 3
) (
  input  logic               game_clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_MOLES-1:0] mole_pattern,
  input  logic               mole_valid,
  input  logic [N_MOLES-1:0] sw,
  output logic [N_MOLES-1:0] mole_led,
  output logic [SCORE_W-1:0] score_inc,
  output logic [MISS_W-1:0]  miss_count,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic               round_active
);

  localparam int unsigned TICK_W = (ROUND_TICKS > 2) ? $clog2(ROUND_TICKS) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(ROUND_TICKS - 1);

  game_state_t        state;
  game_state_t        state_next;
  logic [N_MOLES-1:0] sw_meta;
  logic [N_MOLES-1:0] sw_s;
  logic [N_MOLES-1:0] sw_prev;
  logic [N_MOLES-1:0] toggle;
  logic [N_MOLES-1:0] hit;
  logic [N_MOLES-1:0] remain;
  logic [N_MOLES-1:0] active;
  logic [TICK_W-1:0]  tick;
  logic [SCORE_W-1:0] hit_cnt;
  logic [SCORE_W-1:0] miss_cnt;
  logic [MISS_W:0]    miss_sum;
  logic [LIVES_W-1:0] lives_after;
  logic               pattern_load;

  popcount8 u_hit_count (
    .bits  (hit),
    .count (hit_cnt)
  );

  popcount8 u_miss_count (
    .bits  (active),
    .count (miss_cnt)
  );

  // Judging helpers: whacks on standing moles, survivors, settle-time tallies.
  always_comb begin
    toggle       = sw_s ^ sw_prev;
    hit          = toggle & active;
    remain       = active & ~hit;
    pattern_load = mole_valid && (mole_pattern != '0);
    miss_sum     = {1'b0, miss_count} + {{(MISS_W + 1 - SCORE_W){1'b0}}, miss_cnt};
    lives_after  = lives;
    if ((active != '0) && (lives != '0)) begin
      lives_after = lives - LIVES_W'(1);
    end
  end

  // State register.
  always_ff @(posedge game_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ARM;
      ARM:     state_next = WAIT;
      WAIT:    if (pattern_load) state_next = ROUND;
      ROUND:   if ((tick == LAST_TICK) || (remain == '0)) state_next = SETTLE;
      SETTLE:  state_next = (lives_after == '0) ? OVER : WAIT;
      OVER:    if (start) state_next = ARM;
      default: state_next = IDLE;
    endcase
  end

  // Switch synchroniser and per-state game datapath.
  always_ff @(posedge game_clk) begin
    if (rst) begin
      sw_meta    <= '0;
      sw_s       <= '0;
      sw_prev    <= '0;
      active     <= '0;
      tick       <= '0;
      score_inc  <= '0;
      miss_count <= '0;
      lives      <= LIVES_W'(LIVES_INIT);
    end else begin
      sw_meta   <= sw;
      sw_s      <= sw_meta;
      sw_prev   <= sw_s;
      score_inc <= '0;
      case (state)
        ARM: begin
          miss_count <= '0;
          lives      <= LIVES_W'(LIVES_INIT);
          active     <= '0;
          tick       <= '0;
        end
        WAIT: begin
          if (pattern_load) begin
            active <= mole_pattern;
            tick   <= '0;
          end
        end
        ROUND: begin
          active    <= remain;
          tick      <= tick + TICK_W'(1);
          score_inc <= hit_cnt;
        end
        SETTLE: begin
          miss_count <= miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];
          lives      <= lives_after;
          if (lives_after != '0) begin
            active <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs.
  always_comb begin
    mole_led     = (state == ROUND) ? active : '0;
    game_over    = (state == OVER);
    round_active = (state == ROUND);
  end

endmodule

// File: tb/tb_mole_hit_judge.sv
// Self-checking bench for mole_hit_judge: table vectors, corner-case
// sequences and a randomized run against a game-level reference model.
module tb_mole_hit_judge;

  localparam int unsigned ROUND_TICKS = 4;
  localparam int unsigned LIVES_INIT  = 3;

  localparam int P_IDLE   = 0;
  localparam int P_ARM    = 1;
  localparam int P_WAIT   = 2;
  localparam int P_ROUND  = 3;
  localparam int P_SETTLE = 4;
  localparam int P_OVER   = 5;

  logic       game_clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] mole_pattern;
  logic       mole_valid;
  logic [7:0] sw;
  logic [7:0] mole_led;
  logic [3:0] score_inc;
  logic [7:0] miss_count;
  logic [1:0] lives;
  logic       game_over;
  logic       round_active;

  int checks = 0;
  int errors = 0;

  mole_hit_judge #(
    .ROUND_TICKS (ROUND_TICKS),
    .LIVES_INIT  (LIVES_INIT)
  ) dut (
    .game_clk     (game_clk),
    .rst          (rst),
    .start        (start),
    .mole_pattern (mole_pattern),
    .mole_valid   (mole_valid),
    .sw           (sw),
    .mole_led     (mole_led),
    .score_inc    (score_inc),
    .miss_count   (miss_count),
    .lives        (lives),
    .game_over    (game_over),
    .round_active (round_active)
  );

  always #5 game_clk = ~game_clk;

  // Reference model: game phase, standing moles, elapsed round ticks, tallies,
  // and the last three sampled switch words (a whack is seen two edges late).
  int         m_phase;
  logic [7:0] m_standing;
  int         m_elapsed;
  int         m_lives;
  int         m_misses;
  int         m_score;
  logic [7:0] m_hist [3];

  task automatic model_edge();
    logic [7:0] whack;
    logic [7:0] hits;
    if (rst) begin
      m_phase    = P_IDLE;
      m_standing = 8'h00;
      m_elapsed  = 0;
      m_lives    = LIVES_INIT;
      m_misses   = 0;
      m_score    = 0;
      for (int i = 0; i < 3; i++) m_hist[i] = 8'h00;
    end else begin
      whack   = m_hist[1] ^ m_hist[2];
      m_score = 0;
      case (m_phase)
        P_IDLE: if (start) m_phase = P_ARM;
        P_ARM: begin
          m_misses   = 0;
          m_lives    = LIVES_INIT;
          m_standing = 8'h00;
          m_phase    = P_WAIT;
        end
        P_WAIT: begin
          if (mole_valid && mole_pattern != 8'h00) begin
            m_standing = mole_pattern;
            m_elapsed  = 0;
            m_phase    = P_ROUND;
          end
        end
        P_ROUND: begin
          hits       = whack & m_standing;
          m_score    = $countones(hits);
          m_standing = m_standing & ~hits;
          m_elapsed++;
          if (m_elapsed == ROUND_TICKS || m_standing == 8'h00) m_phase = P_SETTLE;
        end
        P_SETTLE: begin
          m_misses = m_misses + $countones(m_standing);
          if (m_misses > 255) m_misses = 255;
          if (m_standing != 8'h00 && m_lives > 0) m_lives--;
          if (m_lives == 0) begin
            m_phase = P_OVER;
          end else begin
            m_standing = 8'h00;
            m_phase    = P_WAIT;
          end
        end
        default: if (start) m_phase = P_ARM;
      endcase
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = sw;
    end
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compare_model();
    check("model_led",   32'(mole_led),     32'(m_phase == P_ROUND ? m_standing : 8'h00));
    check("model_score", 32'(score_inc),    32'(m_score));
    check("model_miss",  32'(miss_count),   32'(m_misses));
    check("model_lives", 32'(lives),        32'(m_lives));
    check("model_over",  32'(game_over),    32'(m_phase == P_OVER));
    check("model_round", 32'(round_active), 32'(m_phase == P_ROUND));
  endtask

  // One clock: model follows the inputs sampled at the edge, outputs checked #1 later.
  task automatic step();
    @(posedge game_clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic go_wait();
    sw = 8'h00; mole_valid = 1'b0; mole_pattern = 8'h00;
    rst = 1'b1; start = 1'b0; step();
    rst = 1'b0; start = 1'b1; step();
    start = 1'b0; step();
  endtask

  typedef struct {
    logic       r;
    logic       s;
    logic       v;
    logic [7:0] p;
    logic [7:0] w;
    logic [7:0] led;
    logic [3:0] sc;
    logic [7:0] miss;
    logic [1:0] lv;
    logic       ov;
    logic       ra;
  } vec_t;

  function automatic vec_t mkv(logic r, logic s, logic v, logic [7:0] p, logic [7:0] w,
                               logic [7:0] led, logic [3:0] sc, logic [7:0] miss,
                               logic [1:0] lv, logic ov, logic ra);
    vec_t x;
    x.r = r; x.s = s; x.v = v; x.p = p; x.w = w;
    x.led = led; x.sc = sc; x.miss = miss; x.lv = lv; x.ov = ov; x.ra = ra;
    return x;
  endfunction

  vec_t vecs [17];

  initial begin
    // Rows: inputs for one edge, outputs expected just after it.
    vecs[0]  = mkv(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 3, 0, 0);
    vecs[1]  = mkv(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 3, 0, 0);
    vecs[2]  = mkv(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 3, 0, 0);
    vecs[3]  = mkv(0, 0, 1, 8'h05, 8'h00, 8'h05, 0, 0, 3, 0, 1);
    vecs[4]  = mkv(0, 0, 0, 8'h00, 8'h01, 8'h05, 0, 0, 3, 0, 1);
    vecs[5]  = mkv(0, 0, 0, 8'h00, 8'h05, 8'h05, 0, 0, 3, 0, 1);
    vecs[6]  = mkv(0, 0, 0, 8'h00, 8'h05, 8'h04, 1, 0, 3, 0, 1);
    vecs[7]  = mkv(0, 0, 0, 8'h00, 8'h05, 8'h00, 1, 0, 3, 0, 0);
    vecs[8]  = mkv(0, 0, 0, 8'h00, 8'h05, 8'h00, 0, 0, 3, 0, 0);
    vecs[9]  = mkv(0, 0, 1, 8'h81, 8'h05, 8'h81, 0, 0, 3, 0, 1);
    vecs[10] = mkv(0, 0, 0, 8'h00, 8'h05, 8'h81, 0, 0, 3, 0, 1);
    vecs[11] = mkv(0, 0, 0, 8'h00, 8'h05, 8'h81, 0, 0, 3, 0, 1);
    vecs[12] = mkv(0, 0, 0, 8'h00, 8'h05, 8'h81, 0, 0, 3, 0, 1);
    vecs[13] = mkv(0, 0, 0, 8'h00, 8'h05, 8'h00, 0, 0, 3, 0, 0);
    vecs[14] = mkv(0, 0, 0, 8'h00, 8'h05, 8'h00, 0, 2, 2, 0, 0);
    vecs[15] = mkv(0, 0, 1, 8'h03, 8'h05, 8'h03, 0, 2, 2, 0, 1);
    vecs[16] = mkv(0, 0, 1, 8'hFF, 8'h05, 8'h03, 0, 2, 2, 0, 1);

    rst = 1'b1; start = 1'b0; mole_valid = 1'b0; mole_pattern = 8'h00; sw = 8'h00;

    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].r; start = vecs[i].s; mole_valid = vecs[i].v;
      mole_pattern = vecs[i].p; sw = vecs[i].w;
      step();
      check($sformatf("vec%0d_led", i),   32'(mole_led),     32'(vecs[i].led));
      check($sformatf("vec%0d_score", i), 32'(score_inc),    32'(vecs[i].sc));
      check($sformatf("vec%0d_miss", i),  32'(miss_count),   32'(vecs[i].miss));
      check($sformatf("vec%0d_lives", i), 32'(lives),        32'(vecs[i].lv));
      check($sformatf("vec%0d_over", i),  32'(game_over),    32'(vecs[i].ov));
      check($sformatf("vec%0d_round", i), 32'(round_active), 32'(vecs[i].ra));
    end

    // Four moles whacked in one cycle: score 4 and early settle.
    go_wait();
    mole_valid = 1'b1; mole_pattern = 8'h0F; step();
    check("t2_led", 32'(mole_led), 32'h0F);
    mole_valid = 1'b0; sw = 8'h0F; step();
    step();
    step();
    check("t2_score", 32'(score_inc), 32'd4);
    check("t2_early_settle", 32'(round_active), 32'd0);
    step();
    check("t2_miss", 32'(miss_count), 32'd0);
    check("t2_lives", 32'(lives), 32'd3);

    // Three all-miss rounds drain lives to game over.
    go_wait();
    for (int k = 0; k < 3; k++) begin
      mole_valid = 1'b1; mole_pattern = 8'((1 << (k + 1)) - 1); step();
      mole_valid = 1'b0;
      repeat (ROUND_TICKS) step();
      step();
      check($sformatf("t4_lives_r%0d", k), 32'(lives), 32'(2 - k));
    end
    check("t4_over", 32'(game_over), 32'd1);
    check("t4_led", 32'(mole_led), 32'd0);
    check("t4_miss", 32'(miss_count), 32'd6);
    for (int k = 0; k < 6; k++) begin
      sw = ~sw; mole_valid = 1'b1; mole_pattern = 8'hFF; step();
      check("t4_over_score", 32'(score_inc), 32'd0);
      check("t4_over_led", 32'(mole_led), 32'd0);
    end
    mole_valid = 1'b0; start = 1'b1; step();
    start = 1'b0; step();
    check("t4_restart_lives", 32'(lives), 32'd3);
    check("t4_restart_miss", 32'(miss_count), 32'd0);
    check("t4_restart_over", 32'(game_over), 32'd0);

    // Unlit mole toggle scores nothing; final-tick hit counts; later toggle ignored.
    go_wait();
    mole_valid = 1'b1; mole_pattern = 8'h01; step();
    mole_valid = 1'b0; sw = 8'h20; step();
    sw = 8'h21; step();
    sw = 8'h20; step();
    check("t5_unlit_score", 32'(score_inc), 32'd0);
    step();
    check("t5_hit_score", 32'(score_inc), 32'd1);
    check("t5_cleared", 32'(round_active), 32'd0);
    step();
    check("t5_after_score", 32'(score_inc), 32'd0);
    check("t5_miss", 32'(miss_count), 32'd0);
    check("t5_lives", 32'(lives), 32'd3);

    // Reset mid-round overrides start.
    go_wait();
    mole_valid = 1'b1; mole_pattern = 8'h01; step();
    mole_valid = 1'b0;
    repeat (ROUND_TICKS) step();
    step();
    check("t6_pre_lives", 32'(lives), 32'd2);
    mole_valid = 1'b1; mole_pattern = 8'h0F; step();
    mole_valid = 1'b0; step();
    step();
    check("t6_in_round", 32'(round_active), 32'd1);
    rst = 1'b1; start = 1'b1; step();
    check("t6_rst_round", 32'(round_active), 32'd0);
    check("t6_rst_lives", 32'(lives), 32'd3);
    check("t6_rst_led", 32'(mole_led), 32'd0);
    check("t6_rst_miss", 32'(miss_count), 32'd0);
    rst = 1'b0; start = 1'b0; mole_valid = 1'b1; mole_pattern = 8'hFF; step();
    step();
    check("t6_stays_idle", 32'(round_active), 32'd0);
    mole_valid = 1'b0;

    // Toggle arriving with the pattern load in WAIT is not judged.
    go_wait();
    sw = 8'h01; step();
    step();
    mole_valid = 1'b1; mole_pattern = 8'h01; step();
    check("t7_loaded", 32'(mole_led), 32'h01);
    mole_valid = 1'b0; step();
    check("t7_not_judged_led", 32'(mole_led), 32'h01);
    check("t7_not_judged_score", 32'(score_inc), 32'd0);

    // Randomized play against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      start        = ($urandom_range(0, 9) == 0);
      mole_valid   = ($urandom_range(0, 3) == 0);
      mole_pattern = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) mole_pattern = 8'h00;
      if ($urandom_range(0, 2) == 0) sw = sw ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) sw = 8'($urandom_range(0, 255));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
